vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator feeding the sprite drawers (duck, crosshair,
//  background) and the VGA pins. Divides the system clock into a pixel
//  strobe and runs horizontal/vertical counters.
//  Emits hcount/vcount, active-low syncs, video_on, a per-frame strobe and
//  a free-running frame counter for sprite animation.
//  Sits between the board clock and every *_Drawer block.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel (>=1); 50 MHz -> 25 MHz pixel
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BACK     48   horizontal back porch; H_TOTAL = sum of H_* = 800
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BACK     33   vertical back porch; V_TOTAL = sum of V_* = 525
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  pixel_tick   out  1   1-clk strobe, one per pixel period
//  hcount       out  10  pixel column, 0..H_TOTAL-1
//  vcount       out  10  line, 0..V_TOTAL-1
//  hsync        out  1   active-low horizontal sync
//  vsync        out  1   active-low vertical sync
//  video_on     out  1   1 when hcount<H_VISIBLE && vcount<V_VISIBLE
//  frame_start  out  1   1-clk strobe on the tick that wraps counters to (0,0)
//  frame_count  out  8   frames completed since reset, wraps 255->0
// BEHAVIOUR
//  One clock and one reset: clk; reset is synchronous and active-low.
//  Reset (reset==0 at posedge):
//   - div=0, hcount=0, vcount=0, frame_count=0.
//   - pixel_tick=0, frame_start=0, hsync=1, vsync=1, video_on=0.
//  Divider: div counts 0..CLK_DIV-1, then wraps.
//   - pixel_tick is registered, high the clk after div==CLK_DIV-1.
//   - Period is exactly CLK_DIV clks. CLK_DIV=1 gives pixel_tick held high.
//  Counters advance only on clks where pixel_tick==1:
//   - hcount++. At H_TOTAL-1, hcount->0 and vcount++.
//   - At (H_TOTAL-1, V_TOTAL-1), hcount->0 and vcount->0.
//  Decoded outputs (hsync, vsync, video_on) are registered from the
//  next-state counter values. They are valid in the same cycle as the
//  hcount/vcount they describe (zero lag vs counters).
//   - hsync=0 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC
//     (656..751 at defaults).
//   - vsync=0 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC
//     (490..491 at defaults).
//  frame_start: high for exactly the one clk where the counters move to (0,0).
//   - On that same edge frame_count increments, wrapping 255->0.
//  First clk after reset release: counters (0,0), video_on=1, syncs high.
//   - No frame_start on this clk; the first frame_start comes at the first
//     real wrap.
//  Reset mid-frame: all state returns to reset values on that edge,
//  whatever the phase. No partial strobe is emitted.
//  Counters never exceed H_TOTAL-1 / V_TOTAL-1. All arithmetic is 10-bit
//  unsigned.
// TESTING
//  1. Hold reset=0 for 3 clks -> hcount=0, vcount=0, hsync=1, vsync=1,
//     video_on=0, pixel_tick=0, frame_count=0.
//  2. Release reset, run 20 clks -> pixel_tick on every 2nd clk; hcount
//     increments once per tick; video_on=1 on the first clk after release.
//  3. Run one line -> hsync low for exactly 96 ticks, hcount 656..751.
//     video_on drops at hcount=640. hcount 799->0 with vcount 0->1.
//  4. Run to vcount 490..491 -> vsync low for exactly 2*800 ticks.
//     video_on stays 0 for vcount 480..524.
//  5. Run 2 full frames (2*800*525*2 clks) -> frame_start pulses twice,
//     1 clk wide, coincident with (0,0); frame_count 0->1->2.
//  6. Assert reset at (hcount=300, vcount=200) for 1 clk -> next clk all
//     outputs at reset values, no frame_start; normal restart follows.
//     Also preload frame_count=255 and wrap one frame -> frame_count=0.

Source files
------------

// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync_gen to the sprite drawers and VGA pins.
// Latency: none; this is a plain grouping of wires.
// Backpressure: none; timing is free-running, and consumers sample it each clock.
//
// Signals:
//   pixel_tick   1-clk strobe, one per pixel period
//   hcount       pixel column, 0..H_TOTAL-1
//   vcount       line, 0..V_TOTAL-1
//   hsync/vsync  active-low syncs
//   video_on     1 inside the visible window
//   frame_start  1-clk strobe on the tick that wraps the counters to (0,0)
//   frame_count  completed frames since reset, wraps 255->0
interface vga_sync_if;
    logic       pixel_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output pixel_tick, hcount, vcount, hsync, vsync,
               video_on, frame_start, frame_count
    );

    modport slave (
        input  pixel_tick, hcount, vcount, hsync, vsync,
               video_on, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-clock divider plus horizontal/vertical counters.
// Latency: the decoded syncs and video_on are registered alongside the counters.
//          They describe the hcount/vcount shown in the same cycle.
// Backpressure: none; the generator is free-running and cannot be stalled.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   vga    vga_sync_if.master carrying all timing outputs
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // CLK_DIV=1 still needs a 1-bit divider register; it simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             div_last;
    logic             pixel_tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             frame_start;
    logic [7:0]       frame_count;

    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             frame_wrap;

    assign div_last = (div == DIV_LAST);

    // Next-state counters. The decoders below use these values so that
    // the registered syncs line up with the registered counters.
    always_comb begin
        h_nxt      = hcount;
        v_nxt      = vcount;
        frame_wrap = 1'b0;
        if (pixel_tick) begin
            if (hcount == H_LAST) begin
                h_nxt = 10'd0;
                if (vcount == V_LAST) begin
                    v_nxt      = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vcount + 10'd1;
                end
            end else begin
                h_nxt = hcount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div         <= '0;
            pixel_tick  <= 1'b0;
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            div         <= div_last ? '0 : div + DIV_W'(1);
            pixel_tick  <= div_last;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
            vsync       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
            video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign vga.pixel_tick  = pixel_tick;
    assign vga.hcount      = hcount;
    assign vga.vcount      = vcount;
    assign vga.hsync       = hsync;
    assign vga.vsync       = vsync;
    assign vga.video_on    = video_on;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_count;
endmodule
